// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: turns front-panel presses into two operands, one ALU start
// and a held result for the seven-segment display.
module alu_op_sequencer #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        next,
  input  logic [2:0]  MS,
  input  logic [3:0]  Din,
  input  logic        level,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic [15:0] result,
  output logic        Done_out,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state
);

  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]      LAST_DIGIT = 3'(DIGITS);
  localparam logic [TW-1:0]   LAST_WAIT  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   WAIT_STEP  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_SHOW   = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [2:0]    r_cnt;
  logic [TW-1:0] r_wait;
  logic [15:0]   r_opA;
  logic [15:0]   r_opB;
  logic [15:0]   r_result;
  logic [2:0]    r_aluOp;
  logic          r_err;

  logic          w_press;
  logic [2:0]    w_cntNext;
  logic          w_operandEnd;

  assign w_press      = r_s3 & ~r_s2;
  assign w_cntNext    = r_cnt + 3'd1;
  assign w_operandEnd = level | (w_cntNext == LAST_DIGIT);

  // Two-flop synchronizer plus one delay flop; idle level of the button is 1.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= next;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_wait   <= '0;
      r_opA    <= 16'h0000;
      r_opB    <= 16'h0000;
      r_result <= 16'h0000;
      r_aluOp  <= 3'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_opA    <= {12'b0, Din};
            r_opB    <= 16'h0000;
            r_result <= 16'h0000;
            r_err    <= 1'b0;
            if (level || DIGITS == 1) begin
              r_cnt   <= 3'd0;
              r_state <= S_LOAD_B;
            end else begin
              r_cnt   <= 3'd1;
              r_state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (w_press) begin
            r_opA <= {r_opA[11:0], Din};
            if (w_operandEnd) begin
              r_cnt   <= 3'd0;
              r_state <= S_LOAD_B;
            end else begin
              r_cnt <= w_cntNext;
            end
          end
        end
        S_LOAD_B: begin
          if (w_press) begin
            r_opB <= {r_opB[11:0], Din};
            r_cnt <= w_cntNext;
            if (w_operandEnd) r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_aluOp <= MS;
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        // A done arriving on the final timeout cycle takes priority over the error.
        S_WAIT: begin
          if (alu_done) begin
            r_result <= alu_result;
            r_state  <= S_SHOW;
          end else if (r_wait == LAST_WAIT) begin
            r_result <= 16'h0000;
            r_err    <= 1'b1;
            r_state  <= S_SHOW;
          end else begin
            r_wait <= r_wait + WAIT_STEP;
          end
        end
        S_SHOW: begin
          if (w_press) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_a      = r_opA;
  assign op_b      = r_opB;
  assign alu_op    = r_aluOp;
  assign result    = r_result;
  assign err       = r_err;
  assign alu_start = (r_state == S_ISSUE);
  assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign Done_out  = (r_state == S_SHOW);
  assign state     = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a reference model tracks the expected
// outputs every cycle, and literal checks pin the key scenarios.
module tb_alu_op_sequencer;

  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 16;

  logic        clk        = 1'b0;
  logic        clear      = 1'b1;
  logic        next       = 1'b1;
  logic [2:0]  MS         = 3'd0;
  logic [3:0]  Din        = 4'd0;
  logic        level      = 1'b0;
  logic        alu_done   = 1'b0;
  logic [15:0] alu_result = 16'hDEAD;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic [15:0] result;
  logic        Done_out;
  logic        busy;
  logic        err;
  logic [2:0]  state;

  int nTests = 0;
  int nFail  = 0;

  int          aluLatency = -1;
  logic [15:0] aluValue   = 16'h0000;
  int          startCount = 0;
  int          busyCount  = 0;

  int mPhase      = 0;
  int mOpA        = 0;
  int mOpB        = 0;
  int mOp         = 0;
  int mResult     = 0;
  int mErr        = 0;
  int mADigits    = 0;
  int mBDigits    = 0;
  int mWaitCycles = 0;
  int hist[$]     = '{1, 1, 1};

  alu_op_sequencer #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clear(clear), .next(next), .MS(MS), .Din(Din), .level(level),
    .alu_done(alu_done), .alu_result(alu_result), .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .alu_start(alu_start), .result(result), .Done_out(Done_out),
    .busy(busy), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    mPhase = 0; mOpA = 0; mOpB = 0; mOp = 0; mResult = 0; mErr = 0;
    mADigits = 0; mBDigits = 0; mWaitCycles = 0;
    hist = '{1, 1, 1};
  endtask

  // hist holds the button level seen at the last three edges, oldest first;
  // a press acts two edges after the first low sample.
  task automatic stepModel();
    bit press;
    press = (hist[0] == 1) && (hist[1] == 0);
    case (mPhase)
      0: if (press) begin
        mOpA = int'(Din); mOpB = 0; mResult = 0; mErr = 0;
        mADigits = 1; mBDigits = 0;
        mPhase = (level || DIGITS == 1) ? 2 : 1;
      end
      1: if (press) begin
        mOpA = (mOpA * 16 + int'(Din)) % 65536;
        mADigits++;
        if (level || mADigits == DIGITS) mPhase = 2;
      end
      2: if (press) begin
        mOpB = (mOpB * 16 + int'(Din)) % 65536;
        mBDigits++;
        if (level || mBDigits == DIGITS) mPhase = 3;
      end
      3: begin
        mOp = int'(MS); mWaitCycles = 0; mPhase = 4;
      end
      4: begin
        mWaitCycles++;
        if (alu_done) begin
          mResult = int'(alu_result); mPhase = 5;
        end else if (mWaitCycles == TIMEOUT) begin
          mResult = 0; mErr = 1; mPhase = 5;
        end
      end
      5: if (press) mPhase = 0;
      default: mPhase = 0;
    endcase
    void'(hist.pop_front());
    hist.push_back(next ? 1 : 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (clear) resetModel();
      else stepModel();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) startCount++;
      if (busy === 1'b1) busyCount++;
      checkOutput("state", 32'(state), 32'(mPhase));
      checkOutput("op_a", 32'(op_a), 32'(mOpA));
      checkOutput("op_b", 32'(op_b), 32'(mOpB));
      checkOutput("alu_op", 32'(alu_op), 32'(mOp));
      checkOutput("result", 32'(result), 32'(mResult));
      checkOutput("err", 32'(err), 32'(mErr));
      checkOutput("alu_start", 32'(alu_start), 32'(mPhase == 3));
      checkOutput("busy", 32'(busy), 32'(mPhase == 3 || mPhase == 4));
      checkOutput("Done_out", 32'(Done_out), 32'(mPhase == 5));
    end
  end

  // ALU stand-in: raises done for one cycle aluLatency cycles after a start.
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1 && aluLatency >= 0) begin
        repeat (aluLatency) @(negedge clk);
        #1 alu_done = 1'b1; alu_result = aluValue;
        @(negedge clk);
        #1 alu_done = 1'b0; alu_result = 16'hDEAD;
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] din, input logic lvl);
    @(negedge clk);
    #1 Din = din; level = lvl; next = 1'b0;
    repeat (3) @(negedge clk);
    #1 next = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitForDone(input int limit);
    int n;
    n = 0;
    while (Done_out !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneWithinBudget", 32'(Done_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, nTests=%0d nFail=%0d", nTests, nFail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] fullA[4];
    logic [3:0] fullB[4];
    logic [3:0] toutA[4];
    logic [3:0] toutB[4];
    fullA = '{4'h1, 4'h2, 4'h3, 4'h4};
    fullB = '{4'h5, 4'h6, 4'h7, 4'h8};
    toutA = '{4'hA, 4'hB, 4'hC, 4'hD};
    toutB = '{4'h1, 4'h0, 4'h0, 4'h1};

    repeat (3) @(negedge clk);
    checkOutput("resetState", 32'(state), 32'd0);
    checkOutput("resetOpA", 32'(op_a), 32'd0);
    checkOutput("resetDone", 32'(Done_out), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    #1 clear = 1'b0;

    // Full four-digit entry, with a stray done while loading A.
    MS = 3'd1; aluLatency = 3; aluValue = 16'h68AC; startCount = 0;
    applyStimulus(fullA[0], 1'b0);
    #1 alu_done = 1'b1; alu_result = 16'hFFFF;
    @(negedge clk);
    #1 alu_done = 1'b0; alu_result = 16'hDEAD;
    for (int i = 1; i < 4; i++) applyStimulus(fullA[i], 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(fullB[i], 1'b0);
    #1 MS = 3'd6;
    waitForDone(40);
    checkOutput("fullOpA", 32'(op_a), 32'h1234);
    checkOutput("fullOpB", 32'(op_b), 32'h5678);
    checkOutput("fullAluOp", 32'(alu_op), 32'd1);
    checkOutput("fullResult", 32'(result), 32'h68AC);
    checkOutput("fullErr", 32'(err), 32'd0);
    checkOutput("fullStarts", 32'(startCount), 32'd1);
    applyStimulus(4'h0, 1'b0);
    checkOutput("ackState", 32'(state), 32'd0);
    checkOutput("ackHoldOpA", 32'(op_a), 32'h1234);

    // Early termination with level on both operands.
    MS = 3'd2; aluValue = 16'h0007; startCount = 0;
    applyStimulus(4'h3, 1'b1);
    checkOutput("earlyAfterOne", 32'(state), 32'd2);
    applyStimulus(4'h4, 1'b1);
    waitForDone(40);
    checkOutput("earlyOpA", 32'(op_a), 32'h0003);
    checkOutput("earlyOpB", 32'(op_b), 32'h0004);
    checkOutput("earlyStarts", 32'(startCount), 32'd1);
    checkOutput("earlyResult", 32'(result), 32'h0007);
    applyStimulus(4'h0, 1'b0);

    // Timeout: ALU never answers.
    MS = 3'd5; aluLatency = -1; startCount = 0; busyCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(toutA[i], 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(toutB[i], 1'b0);
    waitForDone(60);
    checkOutput("toBusyCycles", 32'(busyCount), 32'd17);
    checkOutput("toErr", 32'(err), 32'd1);
    checkOutput("toResult", 32'(result), 32'd0);
    checkOutput("toAluOp", 32'(alu_op), 32'd5);
    applyStimulus(4'h0, 1'b0);
    checkOutput("toAckState", 32'(state), 32'd0);
    checkOutput("toAckErrHeld", 32'(err), 32'd1);
    applyStimulus(4'h9, 1'b0);
    checkOutput("newOpA", 32'(op_a), 32'h0009);
    checkOutput("newOpB", 32'(op_b), 32'd0);
    checkOutput("newResult", 32'(result), 32'd0);
    checkOutput("newErr", 32'(err), 32'd0);
    checkOutput("newState", 32'(state), 32'd1);

    // Press during WAIT must be dropped.
    aluLatency = 12; aluValue = 16'h1357;
    applyStimulus(4'hA, 1'b1);
    checkOutput("ignOpA", 32'(op_a), 32'h009A);
    applyStimulus(4'hB, 1'b1);
    applyStimulus(4'h1, 1'b0);
    checkOutput("ignState", 32'(state), 32'd4);
    checkOutput("ignOpB", 32'(op_b), 32'h000B);
    waitForDone(40);
    checkOutput("ignResult", 32'(result), 32'h1357);
    applyStimulus(4'h0, 1'b0);

    // Done arrives on the very last WAIT cycle.
    aluLatency = 16; aluValue = 16'hBEEF; busyCount = 0;
    applyStimulus(4'h2, 1'b1);
    applyStimulus(4'h3, 1'b1);
    waitForDone(60);
    checkOutput("edgeResult", 32'(result), 32'hBEEF);
    checkOutput("edgeErr", 32'(err), 32'd0);
    checkOutput("edgeBusyCycles", 32'(busyCount), 32'd17);
    applyStimulus(4'h0, 1'b0);

    // Asynchronous clear in the middle of operand B.
    aluLatency = 3;
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b1);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    checkOutput("midLoadState", 32'(state), 32'd2);
    checkOutput("midLoadOpB", 32'(op_b), 32'h0034);
    @(negedge clk);
    #1 clear = 1'b1;
    #1;
    checkOutput("clrState", 32'(state), 32'd0);
    checkOutput("clrOpA", 32'(op_a), 32'd0);
    checkOutput("clrOpB", 32'(op_b), 32'd0);
    checkOutput("clrDone", 32'(Done_out), 32'd0);
    checkOutput("clrBusy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1 clear = 1'b0; startCount = 0;
    repeat (20) @(negedge clk);
    checkOutput("clrNoStart", 32'(startCount), 32'd0);
    checkOutput("clrStaysIdle", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
